// File: rtl/decipher_ctrl_if.sv
// Stream pair between the front-end and decipher_ctrl: ciphertext in (s_*), plaintext out (m_*).
// Handshake: a beat transfers on the rising edge where valid && ready. The source holds valid and its payload until that edge, and valid never depends on ready.
interface decipher_ctrl_if #(
    parameter int BLK_W = 128,
    parameter int TAG_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [BLK_W-1:0] s_data;
    logic [TAG_W-1:0] s_tag;
    logic             m_valid;
    logic             m_ready;
    logic [BLK_W-1:0] m_data;
    logic [TAG_W-1:0] m_tag;

    modport slave (
        input  s_valid, s_data, s_tag, m_ready,
        output s_ready, m_valid, m_data, m_tag
    );

    modport master (
        output s_valid, s_data, s_tag, m_ready,
        input  s_ready, m_valid, m_data, m_tag
    );
endinterface

// File: rtl/decipher_ctrl.sv
// Sequencer and round-key server for the iterative AES decipher core.
// Holds the key schedule, launches one block at a time and returns plaintext with its tag.
module decipher_ctrl #(
    parameter int NR    = 10,
    parameter int RND_W = 4,
    parameter int BLK_W = 128,
    parameter int KEY_W = 128,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_wr_en,
    input  logic [RND_W-1:0]     key_wr_addr,
    input  logic [KEY_W-1:0]     key_wr_data,
    input  logic                 key_commit,
    output logic                 key_ready,
    output logic                 key_err,
    decipher_ctrl_if.slave       strm,
    output logic                 core_en,
    output logic [BLK_W-1:0]     core_ciphertext,
    output logic [KEY_W-1:0]     core_round_key,
    input  logic [RND_W-1:0]     core_round_no,
    input  logic [BLK_W-1:0]     core_plaintext,
    input  logic                 core_en_o,
    output logic                 busy,
    output logic                 dbg_state
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [RND_W-1:0] LP_NR = RND_W'(NR);

    state_t           r_state;
    logic [TAG_W-1:0] r_tag;
    logic [KEY_W-1:0] r_key_mem [0:NR];

    logic w_idle;
    logic w_wr_ok;
    logic w_commit_ok;
    logic w_key_err;
    logic w_s_fire;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_wr_ok     = key_wr_en && w_idle && (key_wr_addr <= LP_NR);
    assign w_commit_ok = key_commit && w_idle && !key_wr_en;
    assign w_key_err   = (key_wr_en && !w_wr_ok) || (key_commit && !w_idle);

    // A pending key write blocks acceptance, so a block never starts on a half-written schedule.
    assign strm.s_ready = w_idle && key_ready && !key_wr_en
                          && (!strm.m_valid || strm.m_ready);
    assign w_s_fire     = strm.s_valid && strm.s_ready;
    assign dbg_state    = r_state;

    // Key store is deliberately not reset; key_ready gates its use.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_key_mem[key_wr_addr] <= key_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_round_key <= '0;
        end else if (core_round_no <= LP_NR) begin
            core_round_key <= r_key_mem[core_round_no];
        end else begin
            core_round_key <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_tag           <= '0;
            key_ready       <= 1'b0;
            key_err         <= 1'b0;
            core_en         <= 1'b0;
            core_ciphertext <= '0;
            busy            <= 1'b0;
            strm.m_valid    <= 1'b0;
            strm.m_data     <= '0;
            strm.m_tag      <= '0;
        end else begin
            core_en <= 1'b0;
            key_err <= w_key_err;

            if (w_wr_ok) begin
                key_ready <= 1'b0;
            end else if (w_commit_ok) begin
                key_ready <= 1'b1;
            end

            if (strm.m_valid && strm.m_ready) begin
                strm.m_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_s_fire) begin
                        core_ciphertext <= strm.s_data;
                        r_tag           <= strm.s_tag;
                        core_en         <= 1'b1;
                        busy            <= 1'b1;
                        r_state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Acceptance guaranteed the output register is free by now.
                    if (core_en_o) begin
                        strm.m_data  <= core_plaintext;
                        strm.m_tag   <= r_tag;
                        strm.m_valid <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    a_core_en_pulse: assert property (@(posedge clk) disable iff (reset) core_en |=> !core_en);
    a_no_accept_busy: assert property (@(posedge clk) disable iff (reset) busy |-> !strm.s_ready);
endmodule
